// File: rtl/mem_access_unit_pkg.sv
// +----------------------------------------------------------------------------+
// | mem_access_unit_pkg                                                        |
// | Shared size/state encodings and default bus timeout for the load/store unit|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mem_access_unit_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_BUS  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   localparam int TIMEOUT_DEFAULT = 255;

   // Reserved size 2'b11 follows the word rule.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
      logic r;
      case (sz)
         SZ_BYTE: r = 1'b0;
         SZ_HALF: r = lo[0];
         default: r = (lo != 2'b00);
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// +----------------------------------------------------------------------------+
// | mem_lane_align                                                             |
// | Store lane replication / byte enables and load lane extract / extend.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  be_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
      w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (size_i)
         SZ_BYTE: begin
            wdata_o = {4{wdata_i[7:0]}};
            be_o    = 4'b0001 << addr_lo_i;
            rdata_o = unsigned_i ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            wdata_o = {2{wdata_i[15:0]}};
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            rdata_o = unsigned_i ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         end
         default: begin
            wdata_o = wdata_i;
            be_o    = 4'b1111;
            rdata_o = rdata_i;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// +----------------------------------------------------------------------------+
// | mem_access_unit                                                            |
// | Load/store engine between the memory stage and the data-memory bus.        |
// | Optional bus timeout enabled by defining MEM_TIMEOUT_EN.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [1:0]        size,
   input  logic              unsigned_ld,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       r_data,
   output logic              stall,
   output logic              done,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   logic [1:0]        state_q, state_d;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [1:0]        size_q;
   logic [1:0]        alo_q;
   logic              uns_q;
   logic              both_q;

   logic              w_req;
   logic              w_misal;
   logic              w_idle;
   logic [1:0]        w_size;
   logic [1:0]        w_alo;
   logic              w_uns;
   logic [31:0]       w_wdata;
   logic [3:0]        w_be;
   logic [31:0]       w_rdata;

   assign w_req   = MemRead | MemWrite;
   assign w_misal = is_misaligned(size, addr[1:0]);
   assign w_idle  = (state_q == ST_IDLE);

   // One aligner serves both directions: live inputs while accepting, latched ones during BUS.
   assign w_size = w_idle ? size        : size_q;
   assign w_alo  = w_idle ? addr[1:0]   : alo_q;
   assign w_uns  = w_idle ? unsigned_ld : uns_q;

   mem_lane_align u_align (
      .size_i     (w_size),
      .addr_lo_i  (w_alo),
      .unsigned_i (w_uns),
      .wdata_i    (wdata),
      .rdata_i    (mem_rdata),
      .wdata_o    (w_wdata),
      .be_o       (w_be),
      .rdata_o    (w_rdata)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [CNT_W-1:0] cnt_q;
   logic             w_timeout;
   assign w_timeout = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = |TIMEOUT;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (w_req && !w_misal) state_d = ST_BUS;
         ST_BUS: begin
            if (mem_ack) state_d = ST_DONE;
`ifdef MEM_TIMEOUT_EN
            else if (w_timeout) state_d = ST_DONE;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         size_q  <= '0;
         alo_q   <= '0;
         uns_q   <= 1'b0;
         both_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (w_req && w_misal) begin
                  err_q <= 1'b1;
               end else if (w_req) begin
                  we_q    <= MemWrite;
                  addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                  be_q    <= w_be;
                  wdata_q <= w_wdata;
                  size_q  <= size;
                  alo_q   <= addr[1:0];
                  uns_q   <= unsigned_ld;
                  both_q  <= MemRead & MemWrite;
`ifdef MEM_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            ST_BUS: begin
               if (mem_ack) begin
                  if (!we_q) rdata_q <= w_rdata;
                  err_q <= both_q;
               end
`ifdef MEM_TIMEOUT_EN
               else if (w_timeout) begin
                  if (!we_q) rdata_q <= '0;
                  err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign stall     = (w_idle && w_req && !w_misal) || (state_q == ST_BUS);
   assign done      = (state_q == ST_DONE);
   assign mem_req   = (state_q == ST_BUS);
   assign err       = err_q;
   assign r_data    = rdata_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_be    = be_q;
   assign mem_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// +----------------------------------------------------------------------------+
// | tb_mem_access_unit                                                         |
// | Directed self-checking bench for mem_access_unit (timeout case needs      |
// | MEM_TIMEOUT_EN).                                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRead, MemWrite, unsigned_ld;
   logic [1:0]  size;
   logic [31:0] addr, wdata;
   logic [31:0] r_data;
   logic        stall, done, err, mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .size        (size),
      .unsigned_ld (unsigned_ld),
      .addr        (addr),
      .wdata       (wdata),
      .r_data      (r_data),
      .stall       (stall),
      .done        (done),
      .err         (err),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_be      (mem_be),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      MemRead = 1'b0; MemWrite = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
      addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".r_data"},    r_data,    32'h0);
      chk({tag, ".stall"},     stall,     32'h0);
      chk({tag, ".done"},      done,      32'h0);
      chk({tag, ".err"},       err,       32'h0);
      chk({tag, ".mem_req"},   mem_req,   32'h0);
      chk({tag, ".mem_we"},    mem_we,    32'h0);
      chk({tag, ".mem_addr"},  mem_addr,  32'h0);
      chk({tag, ".mem_be"},    mem_be,    32'h0);
      chk({tag, ".mem_wdata"}, mem_wdata, 32'h0);
   endtask

   // Full transaction: request, lat idle BUS cycles, ack, DONE (inputs still held), back to IDLE.
   task automatic xact(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rdat, input int lat, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input logic [31:0] exp_r, input logic exp_err);
      MemRead = rd; MemWrite = wr; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
      #1;
      chk({tag, ".req_stall"}, stall, 32'h1);
      chk({tag, ".req_noreq"}, mem_req, 32'h0);
      tick();
      for (int k = 0; k <= lat; k++) begin
         chk({tag, ".bus_req"},   mem_req,  32'h1);
         chk({tag, ".bus_stall"}, stall,    32'h1);
         chk({tag, ".bus_done"},  done,     32'h0);
         chk({tag, ".mem_addr"},  mem_addr, {a[31:2], 2'b00});
         chk({tag, ".mem_we"},    mem_we,   {31'h0, wr});
         chk({tag, ".mem_be"},    mem_be,   {28'h0, exp_be});
         if (wr) chk({tag, ".mem_wdata"}, mem_wdata, exp_wd);
         if (k == lat) begin
            mem_ack = 1'b1; mem_rdata = rdat;
         end
         tick();
      end
      mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
      #1;
      chk({tag, ".done"},        done,    32'h1);
      chk({tag, ".done_stall"},  stall,   32'h0);
      chk({tag, ".done_req"},    mem_req, 32'h0);
      chk({tag, ".done_err"},    err,     {31'h0, exp_err});
      chk({tag, ".r_data"},      r_data,  exp_r);
      tick();
      idle_inputs();
      #1;
      chk({tag, ".idle_done"},   done,    32'h0);
      chk({tag, ".idle_req"},    mem_req, 32'h0);
      chk({tag, ".idle_err"},    err,     32'h0);
      chk({tag, ".idle_stall"},  stall,   32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      tick(); tick();
      rst = 1'b0;
      #1;
      check_all_zero("reset");

      xact("st_word", 1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0,
           4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
      xact("ld_byte_s", 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF1234, 0,
           4'b1000, 32'h0, 32'hFFFFFF80, 1'b0);
      xact("ld_byte_u", 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF1234, 0,
           4'b1000, 32'h0, 32'h00000080, 1'b0);
      xact("st_half", 1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 0,
           4'b1100, 32'hABCDABCD, 32'h00000080, 1'b0);
      xact("ld_half_hi", 1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h7FFF0000, 0,
           4'b1100, 32'h0, 32'h00007FFF, 1'b0);
      xact("st_byte1", 1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h12345678, 32'h0, 1,
           4'b0010, 32'h78787878, 32'h00007FFF, 1'b0);
      xact("ld_half_lo", 1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h12348001, 2,
           4'b0011, 32'h0, 32'hFFFF8001, 1'b0);
      xact("rd_and_wr", 1'b1, 1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, 32'h99999999, 0,
           4'b1111, 32'h11223344, 32'hFFFF8001, 1'b1);
      xact("ld_rsvd_slow", 1'b1, 1'b0, 2'b11, 1'b0, 32'h004, 32'h0, 32'hCAFEF00D, 5,
           4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);

      // Misaligned word load: no transaction, err pulse, no stall.
      MemRead = 1'b1; size = 2'b10; addr = 32'h101;
      #1;
      chk("misal_w.stall", stall, 32'h0);
      tick();
      chk("misal_w.err",   err,     32'h1);
      chk("misal_w.req",   mem_req, 32'h0);
      chk("misal_w.stall2", stall,  32'h0);
      idle_inputs();
      tick();
      chk("misal_w.err_end", err,    32'h0);
      chk("misal_w.req_end", mem_req, 32'h0);
      chk("misal_w.r_data", r_data,  32'hCAFEF00D);

      // Misaligned half store.
      MemWrite = 1'b1; size = 2'b01; addr = 32'h103; wdata = 32'h1111;
      #1;
      chk("misal_h.stall", stall, 32'h0);
      tick();
      idle_inputs();
      #1;
      chk("misal_h.err", err,     32'h1);
      chk("misal_h.req", mem_req, 32'h0);
      tick();
      chk("misal_h.err_end", err, 32'h0);

      // Reset during a long-outstanding load; later ack must be ignored.
      MemRead = 1'b1; size = 2'b10; addr = 32'h300;
      tick();
      chk("rst_mid.bus1", mem_req, 32'h1);
      tick();
      chk("rst_mid.bus2", mem_req, 32'h1);
      chk("rst_mid.addr", mem_addr, 32'h300);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_inputs();
      #1;
      check_all_zero("rst_mid");
      mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
      tick();
      mem_ack = 1'b0;
      #1;
      chk("rst_mid.late_ack_req",  mem_req, 32'h0);
      chk("rst_mid.late_ack_done", done,    32'h0);
      chk("rst_mid.late_ack_rd",   r_data,  32'h0);

`ifdef MEM_TIMEOUT_EN
      xact("to_pre", 1'b1, 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'h00000055, 0,
           4'b1111, 32'h0, 32'h00000055, 1'b0);
      MemRead = 1'b1; size = 2'b10; addr = 32'h020;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("timeout.req", mem_req, 32'h1);
         chk("timeout.err_early", err, 32'h0);
         tick();
      end
      chk("timeout.req_drop", mem_req, 32'h0);
      chk("timeout.done",     done,    32'h1);
      chk("timeout.err",      err,     32'h1);
      chk("timeout.r_data",   r_data,  32'h0);
      tick();
      idle_inputs();
      #1;
      chk("timeout.end_done", done, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
